// File: rtl/spi_master_multi_if.sv
// Bus bundle for the multi-chip-select SPI master: request/config inputs,
// the serial pins and the status outputs.
interface spi_master_multi_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 8
);
  localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  logic              start;
  logic              cpol;
  logic              cpha;
  logic              lsb_first;
  logic [DIV_W-1:0]  clk_div;
  logic [CS_W-1:0]   cs_sel;
  logic [DATA_W-1:0] data_in;
  logic              MISO;
  logic              MOSI;
  logic              SCK;
  logic [NUM_CS-1:0] CS_n;
  logic [DATA_W-1:0] data_out;
  logic              busy;
  logic              done;

  modport master (
    input  start, cpol, cpha, lsb_first, clk_div, cs_sel, data_in, MISO,
    output MOSI, SCK, CS_n, data_out, busy, done
  );

  modport slave (
    output start, cpol, cpha, lsb_first, clk_div, cs_sel, data_in, MISO,
    input  MOSI, SCK, CS_n, data_out, busy, done
  );
endinterface

// File: rtl/spi_master_multi.sv
// SPI master with selectable chip select, CPOL/CPHA modes, bit order and
// SCK divider. Every output is a register loaded from its next-state value.
//
// state | meaning
// IDLE  | waiting for start; SCK follows live cpol, CS_n all high
// SETUP | one half-period with CS_n asserted, SCK at rest
// TRANS | 2*DATA_W SCK edges, one per half-period
// HOLD  | one half-period with CS_n still asserted, SCK at rest
// DONE  | single cycle: CS_n released, done pulse, data_out updated
module spi_master_multi #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 8
) (
  input logic clk,
  input logic reset,
  spi_master_multi_if.master bus
);
  localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int BW   = $clog2(DATA_W);
  localparam int EW   = $clog2(2 * DATA_W + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W);

  typedef enum logic [2:0] {IDLE, SETUP, TRANS, HOLD, DONE} state_t;

  state_t            state_q, state_n;
  logic [DIV_W-1:0]  div_q, div_n, div_cfg_q, div_cfg_n;
  logic [EW-1:0]     edge_q, edge_n, edge_nxt;
  logic [BW-1:0]     bit_q, bit_n;
  logic [DATA_W-1:0] tx_q, tx_n, rx_q, rx_n, dout_q, dout_n;
  logic              cpol_q, cpol_n, cpha_q, cpha_n, lsb_q, lsb_n;
  logic              sck_q, sck_n, mosi_q, mosi_n, busy_q, busy_n, done_q, done_n;
  logic [NUM_CS-1:0] cs_n_q, cs_n_n;
  logic              do_edge;

  // Position in the data word of sequence bit c for the given bit order.
  function automatic logic [BW-1:0] bit_idx(input logic lsb, input logic [BW-1:0] c);
    return lsb ? c : (BW'(DATA_W - 1) - c);
  endfunction

  // One-hot-low chip-select pattern for a device index.
  function automatic logic [NUM_CS-1:0] cs_mask(input logic [CS_W-1:0] sel);
    logic [NUM_CS-1:0] m;
    m = '1;
    for (int i = 0; i < NUM_CS; i++)
      if (sel == CS_W'(i)) m[i] = 1'b0;
    return m;
  endfunction

  // Next-state and next-output computation for the whole transfer sequence.
  always_comb begin
    state_n   = state_q;
    div_n     = div_q;
    div_cfg_n = div_cfg_q;
    edge_n    = edge_q;
    edge_nxt  = '0;
    bit_n     = bit_q;
    tx_n      = tx_q;
    rx_n      = rx_q;
    dout_n    = dout_q;
    cpol_n    = cpol_q;
    cpha_n    = cpha_q;
    lsb_n     = lsb_q;
    sck_n     = sck_q;
    mosi_n    = mosi_q;
    cs_n_n    = cs_n_q;
    busy_n    = 1'b1;
    done_n    = 1'b0;
    do_edge   = 1'b0;

    case (state_q)
      IDLE: begin
        sck_n  = bus.cpol;
        mosi_n = 1'b0;
        cs_n_n = '1;
        busy_n = 1'b0;
        // Out-of-range device index is dropped without any bus activity.
        if (bus.start && (32'(bus.cs_sel) < NUM_CS)) begin
          state_n   = SETUP;
          tx_n      = bus.data_in;
          cpol_n    = bus.cpol;
          cpha_n    = bus.cpha;
          lsb_n     = bus.lsb_first;
          div_cfg_n = bus.clk_div;
          div_n     = bus.clk_div;
          edge_n    = '0;
          bit_n     = '0;
          rx_n      = '0;
          cs_n_n    = cs_mask(bus.cs_sel);
          busy_n    = 1'b1;
          mosi_n    = bus.cpha ? 1'b0 : bus.data_in[bit_idx(bus.lsb_first, '0)];
        end
      end
      SETUP: begin
        if (div_q == '0) begin
          state_n = TRANS;
          div_n   = div_cfg_q;
          do_edge = 1'b1;
        end else begin
          div_n = div_q - DIV_W'(1);
        end
      end
      TRANS: begin
        if (div_q == '0) begin
          div_n = div_cfg_q;
          if (edge_q == LAST_EDGE) state_n = HOLD;
          else                     do_edge = 1'b1;
        end else begin
          div_n = div_q - DIV_W'(1);
        end
      end
      HOLD: begin
        if (div_q == '0) begin
          state_n = DONE;
          cs_n_n  = '1;
          done_n  = 1'b1;
          dout_n  = rx_q;
        end else begin
          div_n = div_q - DIV_W'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        cs_n_n  = '1;
        sck_n   = bus.cpol;
        mosi_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase

    // Odd edges are leading. The sample edge is leading for cpha=0 and
    // trailing for cpha=1; the other edge shifts MOSI, except that with
    // cpha=1 the first leading edge only presents bit 0 and with cpha=0
    // the final trailing edge has nothing left to shift.
    if (do_edge) begin
      edge_nxt = edge_q + EW'(1);
      edge_n   = edge_nxt;
      sck_n    = ~sck_q;
      if (edge_nxt[0] != cpha_q) begin
        rx_n[bit_idx(lsb_q, bit_q)] = bus.MISO;
      end else if (edge_nxt == EW'(1)) begin
        mosi_n = tx_q[bit_idx(lsb_q, bit_q)];
      end else if (edge_nxt != LAST_EDGE) begin
        bit_n  = bit_q + BW'(1);
        mosi_n = tx_q[bit_idx(lsb_q, bit_n)];
      end
    end
  end

  // State, datapath and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      div_q     <= '0;
      div_cfg_q <= '0;
      edge_q    <= '0;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      dout_q    <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      div_q     <= div_n;
      div_cfg_q <= div_cfg_n;
      edge_q    <= edge_n;
      bit_q     <= bit_n;
      tx_q      <= tx_n;
      rx_q      <= rx_n;
      dout_q    <= dout_n;
      cpol_q    <= cpol_n;
      cpha_q    <= cpha_n;
      lsb_q     <= lsb_n;
      sck_q     <= sck_n;
      mosi_q    <= mosi_n;
      cs_n_q    <= cs_n_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
    end
  end

  assign bus.SCK      = sck_q;
  assign bus.MOSI     = mosi_q;
  assign bus.CS_n     = cs_n_q;
  assign bus.data_out = dout_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi: an 8-bit/4-CS instance and a
// 16-bit/6-CS instance sharing clock and reset.
module tb_spi_master_multi;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  spi_master_multi_if #(.DATA_W(8),  .NUM_CS(4), .DIV_W(8)) b8 ();
  spi_master_multi_if #(.DATA_W(16), .NUM_CS(6), .DIV_W(8)) b16 ();

  spi_master_multi #(.DATA_W(8),  .NUM_CS(4), .DIV_W(8)) dut8  (.clk(clk), .reset(reset), .bus(b8.master));
  spi_master_multi #(.DATA_W(16), .NUM_CS(6), .DIV_W(8)) dut16 (.clk(clk), .reset(reset), .bus(b16.master));

  always #5 clk = ~clk;

  // Slave side: loopback, or a device model shifting out dev8_data LSB first
  // on each falling SCK (leading edge in mode 3).
  logic       dev8_en = 1'b0;
  logic       dev8_bit = 1'b0;
  logic [7:0] dev8_data = 8'h00;
  int         dev8_idx = 0;
  assign b8.MISO  = dev8_en ? dev8_bit : b8.MOSI;
  assign b16.MISO = b16.MOSI;

  always @(negedge b8.SCK)
    if (dev8_en && dev8_idx < 8) begin
      dev8_bit = dev8_data[dev8_idx];
      dev8_idx++;
    end

  // SCK edge counter and MOSI capture on rising SCK (the sample edge in
  // both mode 0 and mode 3).
  logic       cnt_en8 = 1'b0;
  int         sck_edges8 = 0;
  logic [7:0] mosi_rec8 = 8'h00;
  always @(b8.SCK) if (cnt_en8) sck_edges8++;
  always @(posedge b8.SCK) if (cnt_en8) mosi_rec8 = {mosi_rec8[6:0], b8.MOSI};

  task automatic xfer8(input logic pol, input logic pha, input logic lsb,
                       input logic [7:0] div, input logic [1:0] sel, input logic [7:0] din,
                       input bit mess, output int lat, output int ndone, output int edges,
                       output logic [3:0] cs_setup, output logic sck_setup,
                       output logic mosi_setup, output bit tmo);
    int cyc;
    bit seen;
    @(negedge clk);
    b8.cpol = pol; b8.cpha = pha; b8.lsb_first = lsb; b8.clk_div = div;
    b8.cs_sel = sel; b8.data_in = din; b8.start = 1'b1;
    sck_edges8 = 0; mosi_rec8 = 8'h00; cnt_en8 = 1'b1;
    cyc = 1; lat = 0; ndone = 0; seen = 0; tmo = 0;
    @(negedge clk);
    cyc = 2; b8.start = 1'b0;
    cs_setup = b8.CS_n; sck_setup = b8.SCK; mosi_setup = b8.MOSI;
    while (b8.busy && cyc < 3000) begin
      if (b8.done) begin
        ndone++;
        if (!seen) begin seen = 1; lat = cyc; cnt_en8 = 1'b0; end
      end
      if (mess && cyc == 6) begin
        b8.start = 1'b1; b8.data_in = ~din; b8.cpol = ~pol; b8.cpha = ~pha;
        b8.lsb_first = ~lsb; b8.clk_div = 8'd5;
      end
      if (mess && cyc == 7) b8.start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    if (b8.busy) tmo = 1;
    cnt_en8 = 1'b0;
    edges = sck_edges8;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++; if (b8.SCK !== 1'b0) begin bad++; $display("FAIL rst_sck: got %b want 0", b8.SCK); end
    total++; if (b8.MOSI !== 1'b0) begin bad++; $display("FAIL rst_mosi: got %b want 0", b8.MOSI); end
    total++; if (b8.CS_n !== 4'hF) begin bad++; $display("FAIL rst_cs: got %b want 1111", b8.CS_n); end
    total++; if (b8.busy !== 1'b0 || b8.done !== 1'b0) begin bad++; $display("FAIL rst_busy_done: got %b%b want 00", b8.busy, b8.done); end
    total++; if (b8.data_out !== 8'h00) begin bad++; $display("FAIL rst_dout: got %h want 00", b8.data_out); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (b8.SCK !== 1'b0 || b8.busy !== 1'b0 || b16.CS_n !== 6'h3F) begin
      bad++; $display("FAIL post_rst_idle: got sck=%b busy=%b cs16=%b want 0 0 111111", b8.SCK, b8.busy, b16.CS_n);
    end
  endtask

  task automatic test_mode0;
    int lat, nd, ed; logic [3:0] cs; logic sk, mo; bit tmo;
    xfer8(1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 8'hA5, 1'b0, lat, nd, ed, cs, sk, mo, tmo);
    total++; if (tmo) begin bad++; $display("FAIL m0_timeout: busy stuck, want idle"); end
    total++; if (cs !== 4'b1110) begin bad++; $display("FAIL m0_cs: got %b want 1110", cs); end
    total++; if (sk !== 1'b0 || mo !== 1'b1) begin bad++; $display("FAIL m0_setup: got sck=%b mosi=%b want 0 1", sk, mo); end
    total++; if (ed != 16) begin bad++; $display("FAIL m0_edges: got %0d want 16", ed); end
    total++; if (nd != 1) begin bad++; $display("FAIL m0_done_cnt: got %0d want 1", nd); end
    total++; if (lat != 20) begin bad++; $display("FAIL m0_latency: got %0d want 20", lat); end
    total++; if (mosi_rec8 !== 8'hA5) begin bad++; $display("FAIL m0_mosi: got %h want a5", mosi_rec8); end
    total++; if (b8.data_out !== 8'hA5) begin bad++; $display("FAIL m0_dout: got %h want a5", b8.data_out); end
    total++; if (b8.CS_n !== 4'hF || b8.done !== 1'b0) begin bad++; $display("FAIL m0_end: got cs=%b done=%b want 1111 0", b8.CS_n, b8.done); end
  endtask

  task automatic test_idle_cpol;
    @(negedge clk); b8.cpol = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (b8.SCK !== 1'b1 || b8.MOSI !== 1'b0 || b8.busy !== 1'b0) begin
      bad++; $display("FAIL idle_cpol: got sck=%b mosi=%b busy=%b want 1 0 0", b8.SCK, b8.MOSI, b8.busy);
    end
  endtask

  task automatic test_mode3;
    int lat, nd, ed; logic [3:0] cs; logic sk, mo; bit tmo;
    dev8_data = 8'h96; dev8_idx = 0; dev8_bit = 1'b0; dev8_en = 1'b1;
    xfer8(1'b1, 1'b1, 1'b1, 8'd3, 2'd1, 8'h3C, 1'b0, lat, nd, ed, cs, sk, mo, tmo);
    dev8_en = 1'b0;
    total++; if (tmo) begin bad++; $display("FAIL m3_timeout: busy stuck, want idle"); end
    total++; if (sk !== 1'b1 || cs !== 4'b1101) begin bad++; $display("FAIL m3_setup: got sck=%b cs=%b want 1 1101", sk, cs); end
    total++; if (ed != 16) begin bad++; $display("FAIL m3_edges: got %0d want 16", ed); end
    total++; if (lat != 74) begin bad++; $display("FAIL m3_latency: got %0d want 74", lat); end
    total++; if (mosi_rec8 !== 8'b0011_1100) begin bad++; $display("FAIL m3_mosi_order: got %b want 00111100", mosi_rec8); end
    total++; if (b8.data_out !== 8'h96) begin bad++; $display("FAIL m3_dout: got %h want 96", b8.data_out); end
    total++; if (b8.SCK !== 1'b1) begin bad++; $display("FAIL m3_sck_rest: got %b want 1", b8.SCK); end
    @(negedge clk); b8.cpol = 1'b0; b8.cpha = 1'b0; b8.lsb_first = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_cs3;
    int lat, nd, ed; logic [3:0] cs; logic sk, mo; bit tmo;
    xfer8(1'b0, 1'b0, 1'b0, 8'd0, 2'd3, 8'h0F, 1'b0, lat, nd, ed, cs, sk, mo, tmo);
    total++; if (cs !== 4'b0111) begin bad++; $display("FAIL cs3: got %b want 0111", cs); end
    total++; if (b8.data_out !== 8'h0F || nd != 1) begin bad++; $display("FAIL cs3_xfer: got %h/%0d want 0f/1", b8.data_out, nd); end
  endtask

  task automatic test_mid_change;
    int lat, nd, ed; logic [3:0] cs; logic sk, mo; bit tmo;
    xfer8(1'b0, 1'b0, 1'b0, 8'd0, 2'd2, 8'h5A, 1'b1, lat, nd, ed, cs, sk, mo, tmo);
    total++; if (ed != 16 || lat != 20) begin bad++; $display("FAIL mid_wave: got edges=%0d lat=%0d want 16 20", ed, lat); end
    total++; if (mosi_rec8 !== 8'h5A) begin bad++; $display("FAIL mid_mosi: got %h want 5a", mosi_rec8); end
    total++; if (b8.data_out !== 8'h5A || nd != 1) begin bad++; $display("FAIL mid_dout: got %h/%0d want 5a/1", b8.data_out, nd); end
    @(negedge clk); b8.cpol = 1'b0; b8.cpha = 1'b0; b8.lsb_first = 1'b0; b8.clk_div = 8'd0;
    repeat (2) @(negedge clk);
    total++; if (b8.busy !== 1'b0) begin bad++; $display("FAIL mid_no_restart: got busy=%b want 0", b8.busy); end
  endtask

  task automatic test_back_to_back16;
    int cyc, nd, gap, cs_err;
    logic [15:0] got [2];
    got[0] = '0; got[1] = '0;
    @(negedge clk);
    b16.cpol = 1'b0; b16.cpha = 1'b0; b16.lsb_first = 1'b0; b16.clk_div = 8'd0;
    b16.cs_sel = 3'd5; b16.data_in = 16'h1234; b16.start = 1'b1;
    cyc = 1; nd = 0; gap = 0; cs_err = 0;
    while (!(nd == 2 && !b16.busy) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) b16.data_in = 16'hC3A5;
      if (b16.done) begin
        if (nd < 2) got[nd] = b16.data_out;
        nd++;
      end else if (b16.busy) begin
        if (b16.CS_n !== 6'b011111) cs_err++;
        if (nd == 1) b16.start = 1'b0;
      end else begin
        if (b16.CS_n !== 6'h3F) cs_err++;
        if (nd == 1) gap++;
      end
    end
    b16.start = 1'b0;
    total++; if (nd != 2) begin bad++; $display("FAIL b2b_done_cnt: got %0d want 2", nd); end
    total++; if (got[0] !== 16'h1234) begin bad++; $display("FAIL b2b_word0: got %h want 1234", got[0]); end
    total++; if (got[1] !== 16'hC3A5) begin bad++; $display("FAIL b2b_word1: got %h want c3a5", got[1]); end
    total++; if (gap != 1) begin bad++; $display("FAIL b2b_gap: got %0d want 1", gap); end
    total++; if (cs_err != 0) begin bad++; $display("FAIL b2b_cs5: got %0d bad cycles want 0", cs_err); end
  endtask

  task automatic test_cs_out_of_range16;
    @(negedge clk); b16.cs_sel = 3'd6; b16.start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) b16.cs_sel = 3'd7;
      total++; if (b16.busy !== 1'b0 || b16.done !== 1'b0 || b16.CS_n !== 6'h3F) begin
        bad++; $display("FAIL cs_oor: got busy=%b done=%b cs=%b want 0 0 111111", b16.busy, b16.done, b16.CS_n);
      end
    end
    b16.start = 1'b0; b16.cs_sel = 3'd0;
    total++; if (b16.data_out !== 16'hC3A5) begin bad++; $display("FAIL cs_oor_dout: got %h want c3a5", b16.data_out); end
  endtask

  task automatic test_reset_mid;
    int cyc;
    @(negedge clk);
    b8.cpol = 1'b0; b8.cpha = 1'b0; b8.lsb_first = 1'b0; b8.clk_div = 8'd1;
    b8.cs_sel = 2'd2; b8.data_in = 8'h33; b8.start = 1'b1;
    sck_edges8 = 0; cnt_en8 = 1'b1; cyc = 0;
    @(negedge clk); b8.start = 1'b0;
    while (sck_edges8 < 5 && cyc < 200) begin @(negedge clk); cyc++; end
    cnt_en8 = 1'b0;
    total++; if (sck_edges8 != 5) begin bad++; $display("FAIL rmid_reach: got %0d edges want 5", sck_edges8); end
    reset = 1'b0;
    #1;
    total++; if (b8.CS_n !== 4'hF || b8.SCK !== 1'b0) begin bad++; $display("FAIL rmid_abort: got cs=%b sck=%b want 1111 0", b8.CS_n, b8.SCK); end
    total++; if (b8.busy !== 1'b0 || b8.done !== 1'b0) begin bad++; $display("FAIL rmid_status: got busy=%b done=%b want 0 0", b8.busy, b8.done); end
    total++; if (b8.data_out !== 8'h00) begin bad++; $display("FAIL rmid_dout: got %h want 00", b8.data_out); end
    b8.cpol = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (b8.done !== 1'b0 || b8.busy !== 1'b0) begin bad++; $display("FAIL rmid_no_done: got done=%b busy=%b want 0 0", b8.done, b8.busy); end
    end
    total++; if (b8.SCK !== 1'b1) begin bad++; $display("FAIL rmid_sck_cpol: got %b want 1", b8.SCK); end
    b8.cpol = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    b8.start = 1'b0; b8.cpol = 1'b0; b8.cpha = 1'b0; b8.lsb_first = 1'b0;
    b8.clk_div = 8'd0; b8.cs_sel = 2'd0; b8.data_in = 8'h00;
    b16.start = 1'b0; b16.cpol = 1'b0; b16.cpha = 1'b0; b16.lsb_first = 1'b0;
    b16.clk_div = 8'd0; b16.cs_sel = 3'd0; b16.data_in = 16'h0000;
    test_reset;
    test_mode0;
    test_idle_cpol;
    test_mode3;
    test_cs3;
    test_mid_change;
    test_back_to_back16;
    test_cs_out_of_range16;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_master_multi.md
SPI_MASTER_MULTI -- requirements
Module: spi_master_multi

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning transfer word width in bits (legal range 4..32).
REQ-002 SHALL have parameter NUM_CS, default 4, meaning number of chip-select lines (legal range 1..8).
REQ-003 SHALL have parameter DIV_W, default 8, meaning width of the clock-divider input.
REQ-004 SHALL have port clk  in  1  system clock, rising-edge active.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1  transfer request, sampled only in IDLE.
REQ-007 SHALL have port cpol  in  1  SCK idle level.
REQ-008 SHALL have port cpha  in  1  clock phase: 0 = sample on leading edge; 1 = sample on trailing edge.
REQ-009 SHALL have port lsb_first  in  1  bit order: 1 = LSB first; 0 = MSB first.
REQ-010 SHALL have port clk_div  in  DIV_W  SCK half-period minus one, in clk cycles.
REQ-011 SHALL have port cs_sel  in  max(1,$clog2(NUM_CS))  index of the target device.
REQ-012 SHALL have port data_in  in  DATA_W  word to transmit.
REQ-013 SHALL have port MISO  in  1  serial data from the device.
REQ-014 SHALL have port MOSI  out  1  serial data to the device.
REQ-015 SHALL have port SCK  out  1  SPI clock.
REQ-016 SHALL have port CS_n  out  NUM_CS  chip selects, active low, one-hot-low when asserted.
REQ-017 SHALL have port data_out  out  DATA_W  last received word.
REQ-018 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-019 SHALL have port done  out  1  one-cycle completion pulse.

Function
REQ-020 SHALL implement states IDLE, SETUP, TRANS, HOLD, DONE; all outputs SHALL be registered.
REQ-021 In IDLE with start=1, SHALL capture data_in, cpol, cpha, lsb_first, clk_div and cs_sel, then enter SETUP on the next clk.
REQ-022 Captured configuration SHALL be held constant until the return to IDLE; input changes mid-transfer SHALL have no effect.
REQ-023 start SHALL be ignored while busy=1.
REQ-024 If cs_sel >= NUM_CS, the request SHALL be ignored: remain in IDLE, no done pulse.
REQ-025 Half-period SHALL be clk_div+1 clk cycles, so clk_div=0 gives SCK = clk/2.
REQ-026 SETUP SHALL last one half-period with CS_n[cs_sel]=0 and SCK=cpol; when cpha=0, MOSI SHALL present the first bit during SETUP.
REQ-027 TRANS SHALL toggle SCK once per half-period for exactly 2*DATA_W edges, after which SCK SHALL rest at cpol.
REQ-028 When cpha=0: MISO SHALL be sampled on each leading (odd-numbered) edge and MOSI advanced on each trailing edge, with no advance after the final edge.
REQ-029 When cpha=1: MOSI SHALL be advanced on each leading edge (the first leading edge presents bit 0 of the sequence) and MISO sampled on each trailing edge.
REQ-030 Bit order SHALL follow the captured lsb_first for both MOSI and MISO; received bits SHALL assemble into data_out in the same order.
REQ-031 The bit counter SHALL count 0..DATA_W-1, with no wrap and no extra edge.
REQ-032 HOLD SHALL last one half-period with CS_n still asserted and SCK=cpol.
REQ-033 DONE SHALL last one clk cycle with all CS_n=1, done=1, and data_out updated in that cycle; the next state SHALL be IDLE.
REQ-034 data_out SHALL hold its value until the next completed transfer and SHALL be unchanged by an aborted transfer.
REQ-035 In IDLE, SCK SHALL equal the live cpol input, MOSI=0, CS_n all 1, busy=0, done=0.
REQ-036 Back-to-back transfers SHALL be supported: start held high yields a new SETUP one clk after DONE, with CS_n deasserted for at least that one IDLE cycle.

Reset
REQ-037 On reset=0, asynchronously: state=IDLE, SCK=0, MOSI=0, CS_n all 1, busy=0, done=0, data_out=0, all counters and shift registers cleared.
REQ-038 Reset asserted mid-transfer SHALL abort immediately with no done pulse; after release, SCK SHALL follow the cpol input.

Verification
REQ-039 DATA_W=8, mode 0, MSB first, clk_div=0, cs_sel=0, data_in=0xA5, MISO loopback from MOSI -> 16 SCK edges, CS_n=4'b1110 during transfer, done pulses once, data_out=0xA5, total latency 1+1+16+1+1 clk.
REQ-040 Mode 3 (cpol=1, cpha=1), lsb_first=1, clk_div=3, data_in=0x3C, device model returns 0x96 -> SCK idles high, each half-period = 4 clk, MOSI order 0,0,1,1,1,1,0,0, data_out=0x96.
REQ-041 cs_sel=3 on NUM_CS=4 -> CS_n=4'b0111 only; cs_sel=5 on NUM_CS=6 with the same sequence -> CS_n one-hot-low at bit 5; out-of-range cs_sel -> no activity.
REQ-042 start pulsed again mid-transfer, and data_in/cpol changed mid-transfer -> ignored; waveform and data_out unchanged.
REQ-043 reset asserted after the 5th SCK edge -> CS_n all 1 and SCK=0 immediately, no done pulse, data_out retains its prior value (0 after reset).
REQ-044 DATA_W=16, start held high for two transfers -> two done pulses, CS_n high for at least 1 clk between them, both words correct.
